// File: rtl/pool_result_fifo_pkg.sv
// Shared constants and types for the pooled-result buffering slice.
package pool_result_fifo_pkg;

  localparam int unsigned PIXEL_WIDTH        = 8;
  localparam int unsigned IMAGE_WIDTH        = 8;
  localparam int unsigned POOL               = 2;
  localparam int unsigned POOL_FRAME_OUTPUTS = (IMAGE_WIDTH / POOL) * (IMAGE_WIDTH / POOL);

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_result_fifo_if.sv
// Pool-stage capture port and valid/ready result port of pool_result_fifo.
interface pool_result_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/pool_result_fifo_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO: storage, pointers and occupancy.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);
  assign level = count;
  assign do_rd = rd_en & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pool_result_fifo.sv
// Buffers pooled pixels, tags frame ends and flags dropped pushes.
// Optional drop counter enabled by POOL_RESULT_FIFO_STATS_EN.
module pool_result_fifo
  import pool_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = PIXEL_WIDTH,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FRAME_OUTPUTS = POOL_FRAME_OUTPUTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pool_result_fifo_if.slave      bus,
  output logic                   frame_done,
  output logic                   overflow,
`ifdef POOL_RESULT_FIFO_STATS_EN
  output logic [15:0]            drop_count,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned CW = cnt_width(FRAME_OUTPUTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_OUTPUTS - 1);

  logic [CW-1:0]     in_cnt;
  logic [CW-1:0]     out_cnt;
  logic [DATA_WIDTH:0] head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              accepted;
  logic              drop;

  assign push     = bus.in_valid;
  assign pop      = bus.out_valid & bus.out_ready;
  assign accepted = push & (~full | pop);
  assign drop     = push & full & ~pop;

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (flush),
    .wr_en   (push),
    .wr_data ({(in_cnt == LAST_IDX), bus.in_data}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head[DATA_WIDTH-1:0];
  assign bus.out_last  = head[DATA_WIDTH] & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (flush) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accepted) in_cnt  <= (in_cnt == LAST_IDX)  ? '0 : in_cnt + 1'b1;
      if (pop)      out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + 1'b1;
      frame_done <= pop & head[DATA_WIDTH];
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef POOL_RESULT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (flush) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule
